mux2to1_rr_arb: RTL and testbench

//  Round-robin arbiter that shares one 2:1 mux datapath between two requesters.

---
 rtl/mux2to1_rr_arb_if.sv | 22 ++
 rtl/mux2to1_rr_arb.sv | 87 ++++++++
 tb/tb_mux2to1_rr_arb.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux2to1_rr_arb_if.sv
// rtl/mux2to1_rr_arb_if.sv - request/data/grant bundle between requesters and the round-robin mux arbiter
interface mux2to1_rr_arb_if #(
    parameter int W = 8
);
    logic [1:0]   req;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         sel;
    logic [1:0]   grant;
    logic         busy;
    logic [W-1:0] out;

    modport master (
        output req, in0, in1,
        input  sel, grant, busy, out
    );

    modport slave (
        input  req, in0, in1,
        output sel, grant, busy, out
    );
endinterface

// File: rtl/mux2to1_rr_arb.sv
// rtl/mux2to1_rr_arb.sv - round-robin owner arbiter with hold-limit preemption driving a 2:1 mux
module mux2to1_rr_arb #(
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux2to1_rr_arb_if.slave   bus
);
    localparam int HW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int LIMIT_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HW-1:0] LIMIT = LIMIT_I[HW-1:0];

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic            last;
    logic            sel_q;
    logic [1:0]      grant_q;
    logic            busy_q;
    logic [HW-1:0]   hold_cnt;

    logic            pick;
    logic            owner_req;
    logic            other_req;
    logic            preempt;

    // Tie goes to the requester that did not own last; otherwise the single requester.
    always_comb begin
        pick      = (bus.req == 2'b11) ? ~last : bus.req[1];
        owner_req = bus.req[sel_q];
        other_req = bus.req[~sel_q];
        preempt   = (MAX_HOLD != 0) && other_req && (hold_cnt == LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_q  <= 2'b00;
            busy_q   <= 1'b0;
            sel_q    <= 1'b0;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        state    <= BUSY;
                        grant_q  <= {pick, ~pick};
                        busy_q   <= 1'b1;
                        sel_q    <= pick;
                        last     <= pick;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!owner_req && !other_req) begin
                        state    <= IDLE;
                        grant_q  <= 2'b00;
                        busy_q   <= 1'b0;
                        hold_cnt <= '0;
                    end else if (!owner_req || preempt) begin
                        // Release with the other waiting, or hold limit reached: hand over with no idle gap.
                        grant_q  <= {~sel_q, sel_q};
                        sel_q    <= ~sel_q;
                        last     <= ~sel_q;
                        hold_cnt <= '0;
                    end else if (other_req) begin
                        hold_cnt <= (hold_cnt == LIMIT) ? hold_cnt : hold_cnt + 1'b1;
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel   = sel_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.out   = busy_q ? (sel_q ? bus.in1 : bus.in0) : '0;
endmodule

// File: tb/tb_mux2to1_rr_arb.sv
// tb/tb_mux2to1_rr_arb.sv - vector table, corner sequences and random stimulus against a reference model
module tb_mux2to1_rr_arb;
    logic       clk;
    logic       rst_n;
    logic [1:0] d_req;
    logic [7:0] d_in0;
    logic [7:0] d_in1;
    int         checks;
    int         errors;

    mux2to1_rr_arb_if #(.W(8)) bus4 ();
    mux2to1_rr_arb_if #(.W(8)) bus0 ();

    assign bus4.req = d_req;
    assign bus4.in0 = d_in0;
    assign bus4.in1 = d_in1;
    assign bus0.req = d_req;
    assign bus0.in0 = d_in0;
    assign bus0.in1 = d_in1;

    mux2to1_rr_arb #(.W(8), .MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    mux2to1_rr_arb #(.W(8), .MAX_HOLD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [7:0] in0;
        logic [7:0] in1;
        logic [1:0] grant;
        logic       sel;
        logic [7:0] out;
    } vec_t;

    // owner = -1 when idle; waited = contiguous edges the other side has waited on this owner
    typedef struct {
        int owner;
        int last;
        int sel;
        int waited;
    } model_t;

    model_t m4;
    model_t m0;
    vec_t   vecs[13];

    function automatic model_t m_reset();
        model_t s;
        s.owner = -1; s.last = 1; s.sel = 0; s.waited = 0;
        return s;
    endfunction

    function automatic model_t m_step(model_t s, logic [1:0] r, int mh);
        model_t n;
        int o;
        int x;
        n = s;
        if (s.owner < 0) begin
            if (r != 2'b00) begin
                n.owner  = (r == 2'b11) ? 1 - s.last : (r[1] ? 1 : 0);
                n.last   = n.owner;
                n.sel    = n.owner;
                n.waited = 0;
            end
        end else begin
            o = s.owner;
            x = 1 - o;
            if (!r[o]) begin
                if (r[x]) begin
                    n.owner = x; n.last = x; n.sel = x; n.waited = 0;
                end else begin
                    n.owner = -1; n.waited = 0;
                end
            end else if (r[x]) begin
                n.waited = s.waited + 1;
                if (mh != 0 && n.waited >= mh) begin
                    n.owner = x; n.last = x; n.sel = x; n.waited = 0;
                end
            end else begin
                n.waited = 0;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag, input model_t s, input logic [1:0] g,
                             input logic sl, input logic b, input logic [7:0] o);
        logic [1:0] eg;
        logic [7:0] eo;
        eg = (s.owner < 0) ? 2'b00 : ((s.owner == 1) ? 2'b10 : 2'b01);
        eo = (s.owner < 0) ? 8'h00 : ((s.sel == 1) ? d_in1 : d_in0);
        chk({tag, " grant"}, 32'(g), 32'(eg));
        chk({tag, " sel"}, 32'(sl), 32'(s.sel));
        chk({tag, " busy"}, 32'(b), 32'(s.owner >= 0));
        chk({tag, " out"}, 32'(o), 32'(eo));
    endtask

    task automatic check_models();
        chk_model("model4", m4, bus4.grant, bus4.sel, bus4.busy, bus4.out);
        chk_model("model0", m0, bus0.grant, bus0.sel, bus0.busy, bus0.out);
    endtask

    task automatic cycle();
        logic [1:0] r;
        r = d_req;
        @(posedge clk);
        if (rst_n) begin
            m4 = m_step(m4, r, 4);
            m0 = m_step(m0, r, 0);
        end
        #1;
        check_models();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " grant"}, 32'(bus4.grant), 32'h0);
        chk({tag, " busy"}, 32'(bus4.busy), 32'h0);
        chk({tag, " sel"}, 32'(bus4.sel), 32'h0);
        chk({tag, " out"}, 32'(bus4.out), 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 8'h11};
        vecs[1]  = '{2'b00, 8'h11, 8'h22, 2'b00, 1'b0, 8'h00};
        vecs[2]  = '{2'b10, 8'h5A, 8'hA5, 2'b10, 1'b1, 8'hA5};
        vecs[3]  = '{2'b00, 8'h5A, 8'hA5, 2'b00, 1'b1, 8'h00};
        vecs[4]  = '{2'b11, 8'h3C, 8'hC3, 2'b01, 1'b0, 8'h3C};
        vecs[5]  = '{2'b11, 8'h3C, 8'hC3, 2'b01, 1'b0, 8'h3C};
        vecs[6]  = '{2'b10, 8'h3C, 8'hC3, 2'b10, 1'b1, 8'hC3};
        vecs[7]  = '{2'b10, 8'h3C, 8'hC3, 2'b10, 1'b1, 8'hC3};
        vecs[8]  = '{2'b00, 8'h3C, 8'hC3, 2'b00, 1'b1, 8'h00};
        vecs[9]  = '{2'b11, 8'h3C, 8'hC3, 2'b01, 1'b0, 8'h3C};
        vecs[10] = '{2'b00, 8'h3C, 8'hC3, 2'b00, 1'b0, 8'h00};
        vecs[11] = '{2'b11, 8'h3C, 8'hC3, 2'b10, 1'b1, 8'hC3};
        vecs[12] = '{2'b00, 8'h3C, 8'hC3, 2'b00, 1'b1, 8'h00};

        // Reset with both requesting
        rst_n = 1'b0;
        d_req = 2'b11;
        d_in0 = 8'h11;
        d_in1 = 8'h22;
        m4 = m_reset();
        m0 = m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        check_models();
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            d_req = vecs[i].req;
            d_in0 = vecs[i].in0;
            d_in1 = vecs[i].in1;
            cycle();
            chk($sformatf("vec%0d grant", i), 32'(bus4.grant), 32'(vecs[i].grant));
            chk($sformatf("vec%0d sel", i), 32'(bus4.sel), 32'(vecs[i].sel));
            chk($sformatf("vec%0d out", i), 32'(bus4.out), 32'(vecs[i].out));
            chk($sformatf("vec%0d busy", i), 32'(bus4.busy), 32'(vecs[i].grant != 2'b00));
        end

        // Preemption after 4 contended cycles, then back again after 4 more
        d_req = 2'b01;
        cycle();
        chk("preempt start", 32'(bus4.grant), 32'h1);
        d_req = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk($sformatf("preempt k%0d", k), 32'(bus4.grant),
                (k < 4) ? 32'h1 : ((k < 8) ? 32'h2 : 32'h1));
        end

        // No preemption when MAX_HOLD is 0
        for (int k = 0; k < 50; k++) begin
            cycle();
            chk("nopreempt hold0", 32'(bus0.grant), 32'h1);
        end
        d_req = 2'b00;
        cycle();
        d_req = 2'b01;
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("solo owner", 32'(bus4.grant), 32'h1);
        end

        // Async reset between edges while busy
        d_req = 2'b11;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        m4 = m_reset();
        m0 = m_reset();
        #1;
        chk_reset_outputs("async reset");
        check_models();
        #1;
        rst_n = 1'b1;
        cycle();
        chk("post reset grant", 32'(bus4.grant), 32'h1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) d_req = 2'($urandom_range(0, 3));
            d_in0 = 8'($urandom);
            d_in1 = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                m4 = m_reset();
                m0 = m_reset();
                #1;
                check_models();
                #1;
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
